multicycle_control_fsm: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle RV32I ControlUnit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same control signals (ALUOp, reg_write, branch, mem_read, mem_write), qualified by state.
- Adds PC/IR write enables, a memory ready handshake with timeout, an illegal-opcode trap, halt control and a retired-instruction counter.
- Sits between the instruction/data memory port and the datapath of the multi-cycle core.

---
 rtl/multicycle_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, with a
// memory-ready timeout, an illegal-opcode trap, halt control and a retire counter.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32,
    parameter int ENABLE_UTYPE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             trap_clr,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic             reg_write,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);
    // state  | meaning
    // IDLE   | halted, waiting for start
    // FETCH  | instruction read, waiting for mem_ready
    // DECODE | opcode latched and classified
    // EXEC   | ALU operation; branches retire here
    // MEM    | load/store data access, waiting for mem_ready
    // WB     | register write-back, retire
    // TRAP   | illegal opcode or memory timeout, waiting for trap_clr
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [2:0] C_R     = 3'd0;
    localparam logic [2:0] C_I     = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_STORE = 3'd3;
    localparam logic [2:0] C_BR    = 3'd4;
    localparam logic [2:0] C_JAL   = 3'd5;
    localparam logic [2:0] C_U     = 3'd6;
    localparam logic [2:0] C_BAD   = 3'd7;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = C_R;
            7'b0010011: classify = C_I;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BR;
            7'b1101111: classify = C_JAL;
            7'b0110111,
            7'b0010111: classify = (ENABLE_UTYPE != 0) ? C_U : C_BAD;
            default:    classify = C_BAD;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [6:0]       opc_q;
    logic [7:0]       wait_q;
    logic             illegal_q, timeout_q;
    logic [CNT_W-1:0] retired_q;
    logic [2:0]       cls;
    logic             mem_wait, wait_expired, retire;

    assign cls          = classify(opc_q);
    assign mem_wait     = (state_q == S_FETCH) || (state_q == S_MEM);
    // mem_ready on the final allowed cycle wins over the timeout
    assign wait_expired = mem_wait && !mem_ready && (wait_q == WAIT_LAST);
    assign retire       = ((state_q == S_EXEC) && (cls == C_BR))
                       || ((state_q == S_MEM) && (cls == C_STORE) && mem_ready)
                       || (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (wait_expired) state_d = S_TRAP;
            S_DECODE: state_d = (classify(opcode) == C_BAD) ? S_TRAP : S_EXEC;
            S_EXEC:   if (cls == C_LOAD || cls == C_STORE) state_d = S_MEM;
                      else if (cls != C_BR) state_d = S_WB;
            S_MEM:    if (mem_ready) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
                      else if (wait_expired) state_d = S_TRAP;
            S_TRAP:   if (trap_clr) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (retire) state_d = stop ? S_IDLE : S_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opc_q <= opcode;
            if (mem_wait && !mem_ready && !wait_expired) wait_q <= wait_q + 8'd1;
            else wait_q <= '0;
            if (wait_expired) timeout_q <= 1'b1;
            if ((state_q == S_DECODE) && (classify(opcode) == C_BAD)) illegal_q <= 1'b1;
            if ((state_q == S_TRAP) && trap_clr) begin
                illegal_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        ALUOp     = 2'b00;
        reg_write = 1'b0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_EXEC: begin
                case (cls)
                    C_R:     ALUOp = 2'b10;
                    C_I:     ALUOp = 2'b11;
                    C_BR:    ALUOp = 2'b01;
                    default: ALUOp = 2'b00;
                endcase
                if (cls == C_BR) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = branch_taken;
                end
            end
            S_MEM: begin
                mem_read  = (cls == C_LOAD);
                mem_write = (cls == C_STORE);
                pc_write  = (cls == C_STORE) && mem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = (cls == C_JAL);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (U-type disabled, 4-bit retire counter).
module tb_multicycle_control_fsm;
    logic       clk = 1'b0;
    logic       rst, start, stop, trap_clr, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic [1:0] ALUOp;
    logic       reg_write, branch, mem_read, mem_write, ir_write, pc_write, pc_src;
    logic [2:0] state;
    logic       illegal, timeout;
    logic [3:0] retired;
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111,
                           OP_AUIPC = 7'b0010111;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(15), .CNT_W(4), .ENABLE_UTYPE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .trap_clr(trap_clr),
        .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .reg_write(reg_write), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; trap_clr = 1'b0;
        branch_taken = 1'b0; mem_ready = 1'b0; opcode = 7'h00;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_enables", {ALUOp, reg_write, branch, mem_read, mem_write, ir_write, pc_write, pc_src}, 0);
        chk("rst_retired", 32'(retired), 0);
        tick(); tick();
        rst = 1'b0;

        // R-type, memory ready at once
        start = 1'b1; mem_ready = 1'b1; opcode = OP_R; #1;
        chk("idle_state", 32'(state), 0);
        tick(); start = 1'b0; #1;
        chk("r_fetch", 32'(state), 1);
        chk("r_fetch_rd_ir", {mem_read, ir_write}, 2'b11);
        tick(); #1;
        chk("r_decode", 32'(state), 2);
        chk("r_decode_en", {reg_write, mem_read, pc_write}, 0);
        tick(); #1;
        chk("r_exec", 32'(state), 3);
        chk("r_aluop", 32'(ALUOp), 2'b10);
        chk("r_exec_rw", 32'(reg_write), 0);
        tick(); #1;
        chk("r_wb", 32'(state), 5);
        chk("r_wb_en", {reg_write, pc_write, pc_src}, 3'b110);
        tick(); #1;
        chk("r_refetch", 32'(state), 1);
        chk("r_retired", 32'(retired), 1);

        // LOAD with 3 wait cycles in MEM
        opcode = OP_LD;
        tick(); tick(); #1;
        chk("ld_exec_aluop", {30'(state), ALUOp}, {30'd3, 2'b00});
        tick(); mem_ready = 1'b0; #1;
        chk("ld_mem1", {29'(state), mem_read, mem_write, reg_write}, {29'd4, 3'b100});
        tick(); #1;
        chk("ld_mem2", {29'(state), mem_read, mem_write, reg_write}, {29'd4, 3'b100});
        tick(); #1;
        chk("ld_mem3", {29'(state), mem_read, mem_write, reg_write}, {29'd4, 3'b100});
        tick(); mem_ready = 1'b1; #1;
        chk("ld_mem4", {29'(state), mem_read, mem_write, reg_write}, {29'd4, 3'b100});
        tick(); stop = 1'b1; #1;
        chk("ld_wb", {29'(state), reg_write, pc_write, pc_src}, {29'd5, 3'b110});
        tick(); #1;
        chk("ld_halt", 32'(state), 0);
        chk("ld_retired", 32'(retired), 2);

        // STORE, then JAL chained
        start = 1'b1; stop = 1'b0; opcode = OP_ST;
        tick(); start = 1'b0;
        tick(); tick(); tick(); #1;
        chk("st_mem", {28'(state), mem_read, mem_write, reg_write, pc_write}, {28'd4, 4'b0101});
        chk("st_pc_src", 32'(pc_src), 0);
        opcode = OP_JAL;
        tick(); #1;
        chk("st_refetch", 32'(state), 1);
        chk("st_retired", 32'(retired), 3);
        tick(); tick(); #1;
        chk("jal_exec", {30'(state), ALUOp}, {30'd3, 2'b00});
        tick(); #1;
        chk("jal_wb", {29'(state), reg_write, pc_write, pc_src}, {29'd5, 3'b111});

        // branch taken, then not taken
        opcode = OP_BR; branch_taken = 1'b1;
        tick(); tick(); tick(); #1;
        chk("bt_exec", {27'(state), ALUOp, branch, pc_write, pc_src},
            {27'd3, 2'b01, 3'b111});
        chk("bt_retired", 32'(retired), 4);
        branch_taken = 1'b0;
        tick(); #1;
        chk("bt_no_wb", 32'(state), 1);
        chk("bt_retired2", 32'(retired), 5);
        tick(); tick(); #1;
        chk("bn_exec", {27'(state), ALUOp, branch, pc_write, pc_src},
            {27'd3, 2'b01, 3'b110});
        chk("bn_rw", 32'(reg_write), 0);
        stop = 1'b1;
        tick(); #1;
        chk("bn_halt", 32'(state), 0);
        chk("bn_retired", 32'(retired), 6);

        // illegal opcodes
        start = 1'b1; stop = 1'b0; opcode = OP_BAD;
        tick(); start = 1'b0;
        tick(); tick(); #1;
        chk("bad_trap", {29'(state), illegal, timeout, mem_read}, {29'd6, 3'b100});
        tick(); trap_clr = 1'b1; #1;
        chk("bad_hold", {28'(state), retired}, {28'd6, 4'd6});
        tick(); trap_clr = 1'b0; #1;
        chk("bad_clr", {30'(state), illegal, timeout}, {30'd0, 2'b00});
        start = 1'b1; opcode = OP_AUIPC;
        tick(); start = 1'b0;
        tick(); tick(); #1;
        chk("auipc_trap", {30'(state), illegal, timeout}, {30'd6, 2'b10});
        trap_clr = 1'b1;
        tick(); trap_clr = 1'b0; #1;
        chk("auipc_clr", {30'(state), illegal, timeout}, {30'd0, 2'b00});

        // fetch timeout after exactly 15 cycles
        start = 1'b1; mem_ready = 1'b0;
        tick(); start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #1;
        chk("to_cycle15", {31'(state), mem_read}, {31'd1, 1'b1});
        tick(); #1;
        chk("to_trap", {30'(state), illegal, timeout}, {30'd6, 2'b01});
        chk("to_retired", 32'(retired), 6);
        trap_clr = 1'b1;
        tick(); trap_clr = 1'b0; #1;
        chk("to_clr", {30'(state), timeout, illegal}, {30'd0, 2'b00});

        // mem_ready on the 15th cycle wins
        start = 1'b1; opcode = OP_R;
        tick(); start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        mem_ready = 1'b1; #1;
        chk("late_ir_write", {31'(state), ir_write}, {31'd1, 1'b1});
        tick(); #1;
        chk("late_decode", {31'(state), timeout}, {31'd2, 1'b0});
        tick(); tick(); tick(); #1;
        chk("late_retired", {28'(state), retired}, {28'd1, 4'd7});

        // async reset mid-MEM
        opcode = OP_LD;
        tick(); tick(); tick(); mem_ready = 1'b0; #1;
        chk("mid_mem", {31'(state), mem_read}, {31'd4, 1'b1});
        #1; rst = 1'b1; #1;
        chk("async_state", 32'(state), 0);
        chk("async_outs", {ALUOp, reg_write, branch, mem_read, mem_write, ir_write, pc_write,
                           pc_src, illegal, timeout, retired}, 0);
        tick(); rst = 1'b0;

        // 17 retirements wrap a 4-bit counter to 1
        start = 1'b1; stop = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        tick(); start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick(); tick(); tick(); tick();
            if (i == 15) begin
                #1;
                chk("wrap16", 32'(retired), 0);
            end
        end
        #1;
        chk("wrap17", 32'(retired), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
